codec_slave: RTL and testbench
==============================

Name: codec_slave

Overview:
- Codec-side (slave) end of the 16-bit left-justified serial audio link. The FPGA-side interface is the master and generates MCLK/SCLK/LRCLK/RSTn.
- Oversamples the master's LRCLK, SCLK and RSTn on clk, deserializes SDin into DAC words, and serializes ADC words onto SDout.
- Used as a synthesizable codec stand-in for loopback and bring-up. Also serves as the bus-level responder in the codec interface testbench.

Parameters:
- DW, 16, bits per channel per LRCLK half-period.
- SYNC_STAGES, 2, flops in each input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low; clock clk
- LRCLK  input  1  frame clock from master; high = left channel, low = right channel
- SCLK  input  1  bit clock from master; at least 8 clk per SCLK period
- RSTn  input  1  codec reset from master, active-low; level-synchronized
- SDin  input  1  serial DAC data from master, MSB first, sampled on SCLK rise
- adc_lft  input  DW  left word to transmit; sampled at LRCLK rise
- adc_rht  input  DW  right word to transmit; sampled at LRCLK rise
- SDout  output  1  serial ADC data to master; changes on SCLK fall
- adc_req  output  1  1-clk pulse when adc_lft/adc_rht are consumed
- dac_lft  output  DW  last complete left word received
- dac_rht  output  DW  last complete right word received
- dac_valid  output  1  1-clk pulse when a new left/right pair is available
- frm_err  output  1  1-clk pulse when a half-frame ended with a bit count other than DW
- in_frame  output  1  high while locked to the frame (LEFT/RIGHT states)

Behaviour:
- Synchronization and edge detection:
  - LRCLK, SCLK, RSTn and SDin each pass through SYNC_STAGES flops.
  - One extra delay flop on LRCLK and SCLK gives rise/fall pulses. Edge latency is SYNC_STAGES+1 clk.
  - SDin is sampled from its synchronized copy when the SCLK-rise pulse fires.
- Reset values: SDout=0, adc_req=0, dac_lft=0, dac_rht=0, dac_valid=0, frm_err=0, in_frame=0, bit counter=0, shift registers=0, state=IDLE.
- Synchronized RSTn low forces IDLE and clears shift registers and the bit counter. dac_lft/dac_rht hold their values. SDout=0.
- States:
  - IDLE: RSTn low. Go to WAIT_SYNC when synced RSTn=1.
  - WAIT_SYNC: discard all bits; SDout=0. On LRCLK rise go to LEFT.
  - LEFT: on LRCLK fall go to RIGHT.
  - RIGHT: on LRCLK rise go to LEFT.
  - Any state: synced RSTn=0 -> IDLE.
- LRCLK rise (entering LEFT, including from WAIT_SYNC):
  - Latch adc_lft/adc_rht into tx buffers; pulse adc_req.
  - Load tx shift register with adc_lft; SDout=MSB the next clk.
- LRCLK fall: load tx shift register from the right tx buffer.
- SCLK fall with no LRCLK edge: shift tx register left, fill 0. SDout = tx[DW-1].
- LRCLK edge and SCLK fall in the same clk (nominal alignment): the load wins and no shift occurs.
- SCLK rise, in LEFT or RIGHT:
  - Shift SDin into the rx register; increment the bit counter (saturating at DW+1).
  - Bits beyond DW are dropped; the rx register keeps the first DW bits.
- LRCLK fall from LEFT:
  - dac_lft <= rx; reset bit counter and rx.
  - If count != DW, pulse frm_err and do not update dac_lft.
- LRCLK rise from RIGHT:
  - dac_rht <= rx (same count check).
  - Pulse dac_valid only if both halves of this frame had count == DW.
  - No dac_valid on the first rise out of WAIT_SYNC.
- Any SCLK rise coincident with an LRCLK edge belongs to the new half.
- in_frame = (state==LEFT or RIGHT), registered.

Decomposition:
- codec_pkg holds:
  - the state typedef (IDLE, WAIT_SYNC, LEFT, RIGHT);
  - the localparam default DW=16;
  - the nominal clk-per-SCLK (32) and SCLK-per-LRCLK (32) constants, used by both the RTL and the bench.
- Sub-module sync_edge:
  - parameterized SYNC_STAGES;
  - outputs the synced level plus rise/fall pulses;
  - instantiated for LRCLK, SCLK and RSTn. SDin uses the level output only.

Test Plan:
- Reset / WAIT_SYNC:
  - Stimulus: hold rst_n low 3 clk, then release with RSTn low for 1024 clk.
  - Required: all outputs 0, state IDLE.
  - Then raise RSTn: in_frame rises only after the first LRCLK rise; no dac_valid on that rise.
- Loopback, nominal timing:
  - Stimulus: master timing (SCLK = clk/32, LRCLK = clk/1024); master sends L=16'hA5C3, R=16'h3C5A; adc_lft=16'h1234, adc_rht=16'hFEDC.
  - Required: dac_valid pulses once per frame with dac_lft=A5C3, dac_rht=3C5A.
  - Required: the master captures 1234/FEDC; adc_req pulses once per frame.
- Bit-order edge values:
  - Stimulus: send 16'h8000 then 16'h0001.
  - Required: dac_lft=8000, dac_rht=0001; SDout for adc_lft=16'h8000 is high only for the first SCLK period of the left half.
- Short half-frame:
  - Stimulus: LRCLK falls after 15 SCLK rises.
  - Required: frm_err pulses, dac_lft unchanged, no dac_valid that frame; the next clean frame gives dac_valid.
- Long half-frame:
  - Stimulus: 17 SCLK rises before LRCLK fall.
  - Required: frm_err pulses; dac_lft not updated.
- RSTn mid-frame:
  - Stimulus: drop RSTn after 8 left bits.
  - Required: IDLE within SYNC_STAGES+1 clk, SDout=0, dac_lft/dac_rht retain their prior values.
  - After re-sync: one full frame passes before the next dac_valid.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared state encoding and nominal link timing for the codec-side serial audio endpoint.
package codec_pkg;

    localparam int unsigned DW_DEFAULT     = 16;
    localparam int unsigned CLK_PER_SCLK   = 32;
    localparam int unsigned SCLK_PER_LRCLK = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        LEFT,
        RIGHT
    } state_t;

endpackage

// File: rtl/codec_slave_sync_edge.sv
// Multi-flop level synchronizer with single-cycle rise/fall pulses on the synchronized level.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/codec_slave.sv
// Codec-side (slave) end of the left-justified serial audio link: oversamples the master's
// clocks, deserializes SDin into DAC words and serializes ADC words onto SDout.
module codec_slave
    import codec_pkg::*;
#(
    parameter int unsigned DW          = DW_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LRCLK,
    input  logic          SCLK,
    input  logic          RSTn,
    input  logic          SDin,
    input  logic [DW-1:0] adc_lft,
    input  logic [DW-1:0] adc_rht,
    output logic          SDout,
    output logic          adc_req,
    output logic [DW-1:0] dac_lft,
    output logic [DW-1:0] dac_rht,
    output logic          dac_valid,
    output logic          frm_err,
    output logic          in_frame
);

    localparam int unsigned   CW       = $clog2(DW + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DW);

    logic lr_lvl, lr_rise, lr_fall;
    logic sc_lvl, sc_rise, sc_fall;
    logic rstn_lvl, rstn_rise, rstn_fall;
    logic sdin_s, sd_rise, sd_fall;
    logic unused_edges;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lr (
        .clk(clk), .rst_n(rst_n), .d(LRCLK), .level(lr_lvl), .rise(lr_rise), .fall(lr_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sc (
        .clk(clk), .rst_n(rst_n), .d(SCLK), .level(sc_lvl), .rise(sc_rise), .fall(sc_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rstn (
        .clk(clk), .rst_n(rst_n), .d(RSTn), .level(rstn_lvl), .rise(rstn_rise), .fall(rstn_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdin (
        .clk(clk), .rst_n(rst_n), .d(SDin), .level(sdin_s), .rise(sd_rise), .fall(sd_fall)
    );

    assign unused_edges = ^{lr_lvl, sc_lvl, rstn_rise, rstn_fall, sd_rise, sd_fall};

    state_t        state;
    logic [DW-1:0] tx_sh;
    logic [DW-1:0] tx_rht;
    logic [DW-1:0] rx_sh;
    logic [CW-1:0] bit_cnt;
    logic          left_ok;

    logic          cnt_ok;
    logic [DW-1:0] tx_next;
    logic [DW-1:0] rx_next;
    logic [CW-1:0] cnt_next;
    logic [DW-1:0] rx_first;
    logic [CW-1:0] cnt_first;

    assign cnt_ok   = (bit_cnt == CNT_FULL);
    assign tx_next  = sc_fall ? {tx_sh[DW-2:0], 1'b0} : tx_sh;
    assign rx_next  = (sc_rise && bit_cnt < CNT_FULL) ? {rx_sh[DW-2:0], sdin_s} : rx_sh;
    assign cnt_next = (sc_rise && bit_cnt <= CNT_FULL) ? bit_cnt + CW'(1) : bit_cnt;

    // An SCLK rise coincident with the LRCLK edge is the first bit of the new half.
    assign rx_first  = {{(DW-1){1'b0}}, sc_rise & sdin_s};
    assign cnt_first = {{(CW-1){1'b0}}, sc_rise};

    assign SDout = tx_sh[DW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_sh     <= '0;
            tx_rht    <= '0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            left_ok   <= 1'b0;
            dac_lft   <= '0;
            dac_rht   <= '0;
            dac_valid <= 1'b0;
            adc_req   <= 1'b0;
            frm_err   <= 1'b0;
            in_frame  <= 1'b0;
        end else begin
            adc_req   <= 1'b0;
            dac_valid <= 1'b0;
            frm_err   <= 1'b0;
            if (!rstn_lvl) begin
                state    <= IDLE;
                tx_sh    <= '0;
                rx_sh    <= '0;
                bit_cnt  <= '0;
                left_ok  <= 1'b0;
                in_frame <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= WAIT_SYNC;
                    end
                    WAIT_SYNC: begin
                        if (lr_rise) begin
                            state    <= LEFT;
                            in_frame <= 1'b1;
                            adc_req  <= 1'b1;
                            tx_sh    <= adc_lft;
                            tx_rht   <= adc_rht;
                            rx_sh    <= rx_first;
                            bit_cnt  <= cnt_first;
                        end
                    end
                    LEFT: begin
                        if (lr_fall) begin
                            if (cnt_ok) dac_lft <= rx_sh;
                            else        frm_err <= 1'b1;
                            left_ok <= cnt_ok;
                            state   <= RIGHT;
                            tx_sh   <= tx_rht;
                            rx_sh   <= rx_first;
                            bit_cnt <= cnt_first;
                        end else begin
                            tx_sh   <= tx_next;
                            rx_sh   <= rx_next;
                            bit_cnt <= cnt_next;
                        end
                    end
                    RIGHT: begin
                        if (lr_rise) begin
                            if (cnt_ok) dac_rht <= rx_sh;
                            else        frm_err <= 1'b1;
                            dac_valid <= left_ok & cnt_ok;
                            state     <= LEFT;
                            adc_req   <= 1'b1;
                            tx_sh     <= adc_lft;
                            tx_rht    <= adc_rht;
                            rx_sh     <= rx_first;
                            bit_cnt   <= cnt_first;
                        end else begin
                            tx_sh   <= tx_next;
                            rx_sh   <= rx_next;
                            bit_cnt <= cnt_next;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_codec_slave.sv
// Scoreboard bench for codec_slave: a bit-level master drives the link, a monitor checks DUT events.
module tb_codec_slave;
    import codec_pkg::*;

    localparam int unsigned DW        = DW_DEFAULT;
    localparam int unsigned HALF_SCLK = CLK_PER_SCLK / 2;
    localparam int unsigned BITS_HALF = SCLK_PER_LRCLK / 2;

    logic          clk = 1'b0;
    logic          rst_n, LRCLK, SCLK, RSTn, SDin;
    logic [DW-1:0] adc_lft, adc_rht;
    logic          SDout, adc_req, dac_valid, frm_err, in_frame;
    logic [DW-1:0] dac_lft, dac_rht;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_req    = 0;
    logic [31:0]   q_dac[$];
    logic [31:0]   q_err[$];
    logic [15:0]   cl, cr;
    int            h;

    always #5 clk = ~clk;

    codec_slave #(.DW(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .LRCLK(LRCLK), .SCLK(SCLK), .RSTn(RSTn), .SDin(SDin),
        .adc_lft(adc_lft), .adc_rht(adc_rht), .SDout(SDout), .adc_req(adc_req),
        .dac_lft(dac_lft), .dac_rht(dac_rht), .dac_valid(dac_valid), .frm_err(frm_err),
        .in_frame(in_frame)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Master side of one LRCLK half: n SCLK periods, MSB first, capturing SDout on SCLK rise.
    task automatic half(input logic lr, input logic [15:0] w, input int n,
                        output logic [15:0] cap, output int highs);
        logic [15:0] sh;
        sh = w;
        cap = '0;
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            SCLK = 1'b0;
            if (i == 0) LRCLK = lr;
            SDin = sh[15];
            sh = sh << 1;
            if (SDout) highs++;
            for (int unsigned k = 1; k < HALF_SCLK; k++) begin
                @(negedge clk);
                if (SDout) highs++;
            end
            @(negedge clk);
            SCLK = 1'b1;
            if (i < int'(BITS_HALF)) cap = {cap[14:0], SDout};
            if (SDout) highs++;
            for (int unsigned k = 1; k < HALF_SCLK; k++) begin
                @(negedge clk);
                if (SDout) highs++;
            end
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r,
                         input logic [15:0] al, input logic [15:0] ar,
                         input int nl, input int nr,
                         output logic [15:0] cap_l, output logic [15:0] cap_r, output int highs_l);
        int hr;
        adc_lft = al;
        adc_rht = ar;
        half(1'b1, l, nl, cap_l, highs_l);
        half(1'b0, r, nr, cap_r, hr);
    endtask

    // Monitor: every DUT event must match the oldest outstanding expectation.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (adc_req) n_req++;
            if (dac_valid) begin
                if (q_dac.size() == 0) begin
                    n_checks++;
                    $display("FAIL dac_valid_unexpected: got pulse lft=%h rht=%h expected none", dac_lft, dac_rht);
                end else begin
                    e = q_dac.pop_front();
                    chk("dac_valid_lft", 64'(dac_lft), 64'(e[31:16]));
                    chk("dac_valid_rht", 64'(dac_rht), 64'(e[15:0]));
                end
            end
            if (frm_err) begin
                if (q_err.size() == 0) begin
                    n_checks++;
                    $display("FAIL frm_err_unexpected: got pulse expected none");
                end else begin
                    e = q_err.pop_front();
                    chk("frm_err_hold", 64'({dac_lft, dac_rht}), 64'(e));
                end
            end
        end
    end

    initial begin
        #(64'd5_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; RSTn = 1'b0; LRCLK = 1'b0; SCLK = 1'b1; SDin = 1'b0;
        adc_lft = '0; adc_rht = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({SDout, adc_req, dac_valid, frm_err, in_frame, dac_lft, dac_rht}), 64'd0);
        rst_n = 1'b1;
        repeat (1024) @(negedge clk);
        chk("idle_outs", 64'({SDout, adc_req, dac_valid, frm_err, in_frame, dac_lft, dac_rht}), 64'd0);
        RSTn = 1'b1;
        repeat (16) @(negedge clk);
        chk("wait_sync_in_frame", 64'(in_frame), 64'd0);

        // Frame 1: first rise out of WAIT_SYNC, its pair is reported on the following rise.
        q_dac.push_back({16'hA5C3, 16'h3C5A});
        adc_lft = 16'h1234; adc_rht = 16'hFEDC;
        half(1'b1, 16'hA5C3, 16, cl, h);
        chk("in_frame_after_rise", 64'(in_frame), 64'd1);
        half(1'b0, 16'h3C5A, 16, cr, h);
        chk("f1_cap_l", 64'(cl), 64'h1234);
        chk("f1_cap_r", 64'(cr), 64'hFEDC);

        q_dac.push_back({16'hA5C3, 16'h3C5A});
        frame(16'hA5C3, 16'h3C5A, 16'h1234, 16'hFEDC, 16, 16, cl, cr, h);
        chk("f2_cap_l", 64'(cl), 64'h1234);
        chk("f2_cap_r", 64'(cr), 64'hFEDC);

        q_dac.push_back({16'h8000, 16'h0001});
        frame(16'h8000, 16'h0001, 16'h8000, 16'h0001, 16, 16, cl, cr, h);
        chk("f3_cap_l", 64'(cl), 64'h8000);
        chk("f3_cap_r", 64'(cr), 64'h0001);
        chk("f3_msb_high_clks", 64'(h), 64'(CLK_PER_SCLK));

        // Short left half: error, dac_lft held, no dac_valid for this frame.
        q_err.push_back({16'h8000, 16'h0001});
        frame(16'h1111, 16'h2222, 16'h0000, 16'h0000, 15, 16, cl, cr, h);

        q_dac.push_back({16'h0F0F, 16'hF0F0});
        frame(16'h0F0F, 16'hF0F0, 16'h0000, 16'h0000, 16, 16, cl, cr, h);

        // Long left half: 17 bits.
        q_err.push_back({16'h0F0F, 16'hF0F0});
        frame(16'hABCD, 16'h1357, 16'h0000, 16'h0000, 17, 16, cl, cr, h);

        q_dac.push_back({16'h2468, 16'h9BDF});
        frame(16'h2468, 16'h9BDF, 16'h1234, 16'hFEDC, 16, 16, cl, cr, h);
        chk("f7_cap_l", 64'(cl), 64'h1234);
        chk("f7_cap_r", 64'(cr), 64'hFEDC);

        // RSTn drop after 8 left bits.
        adc_lft = 16'hFFFF; adc_rht = 16'h0000;
        half(1'b1, 16'h0000, 8, cl, h);
        chk("sdout_before_drop", 64'(SDout), 64'd1);
        RSTn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstn_in_frame", 64'(in_frame), 64'd0);
        chk("rstn_sdout", 64'(SDout), 64'd0);
        chk("rstn_dac_hold", 64'({dac_lft, dac_rht}), 64'h2468_9BDF);
        LRCLK = 1'b0; SCLK = 1'b1; SDin = 1'b0;
        repeat (64) @(negedge clk);
        RSTn = 1'b1;
        repeat (16) @(negedge clk);

        q_dac.push_back({16'h5555, 16'hAAAA});
        frame(16'h5555, 16'hAAAA, 16'h0000, 16'h0000, 16, 16, cl, cr, h);
        adc_lft = '0; adc_rht = '0;
        half(1'b1, 16'h0000, 16, cl, h);
        repeat (8) @(negedge clk);

        chk("dac_q_drained", 64'(q_dac.size()), 64'd0);
        chk("err_q_drained", 64'(q_err.size()), 64'd0);
        chk("adc_req_count", 64'(n_req), 64'd10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
